// File: rtl/mult_control_path.sv
// Sequencer for the repeated-addition multiplier: loads A and B off a shared bus,
// accumulates P += A while counting B down, with a watchdog on the iteration count.
module mult_control_path #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 32767
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic eqz,
  output logic ld_a,
  output logic ld_b,
  output logic clr_p,
  output logic ld_p,
  output logic dec_b,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // State, iteration counter and sticky fault flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and strobe decode; abort overrides every transition and strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    clr_p   = 1'b0;
    ld_p    = 1'b0;
    dec_b   = 1'b0;
    done    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD_A;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD_A: begin
          ld_a    = 1'b1;
          state_d = S_LOAD_B;
        end
        S_LOAD_B: begin
          ld_b    = 1'b1;
          clr_p   = 1'b1;
          state_d = S_ADD;
        end
        S_ADD: begin
          if (eqz) begin
            state_d = S_DONE;
          end else if (cnt_q == MAX_CNT) begin
            // eqz never arrived within the budget: give up and flag the datapath
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            ld_p  = 1'b1;
            dec_b = 1'b1;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_mult_control_path.sv
// Directed bench: a behavioural datapath closes the eqz loop around one instance;
// a second instance with a small watchdog budget has eqz tied low.
module tb_mult_control_path;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: default watchdog, driven by the datapath model
  logic start0 = 1'b0, abort0 = 1'b0, eqz0;
  logic ld_a0, ld_b0, clr_p0, ld_p0, dec_b0, busy0, done0, err0;
  // Instance 1: MAX_ITER=4, eqz stuck low
  logic start1 = 1'b0, abort1 = 1'b0, eqz1 = 1'b0;
  logic ld_a1, ld_b1, clr_p1, ld_p1, dec_b1, busy1, done1, err1;

  mult_control_path u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .eqz(eqz0),
    .ld_a(ld_a0), .ld_b(ld_b0), .clr_p(clr_p0), .ld_p(ld_p0), .dec_b(dec_b0),
    .busy(busy0), .done(done0), .err(err0)
  );

  mult_control_path #(.CNT_W(16), .MAX_ITER(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .eqz(eqz1),
    .ld_a(ld_a1), .ld_b(ld_b1), .clr_p(clr_p1), .ld_p(ld_p1), .dec_b(dec_b1),
    .busy(busy1), .done(done1), .err(err1)
  );

  // Outputs packed as {ld_a, ld_b, clr_p, ld_p, dec_b, done, busy, err}
  logic [7:0] outs0, outs1;
  assign outs0 = {ld_a0, ld_b0, clr_p0, ld_p0, dec_b0, done0, busy0, err0};
  assign outs1 = {ld_a1, ld_b1, clr_p1, ld_p1, dec_b1, done1, busy1, err1};

  // Datapath model: A, B, P registers on a shared 15-bit bus
  logic [14:0] opa = 15'd0, opb = 15'd0;
  logic [14:0] bus, ra, rb;
  logic [15:0] rp;
  assign bus  = ld_a0 ? opa : opb;
  assign eqz0 = (rb == 15'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra <= 15'd0;
      rb <= 15'd0;
      rp <= 16'd0;
    end else begin
      if (ld_a0) ra <= bus;
      if (ld_b0) rb <= bus;
      else if (dec_b0) rb <= rb - 15'd1;
      if (clr_p0) rp <= 16'd0;
      else if (ld_p0) rp <= rp + {1'b0, ra};
    end
  end

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LDA  = 8'b1000_0010;
  localparam logic [7:0] O_LDB  = 8'b0110_0010;
  localparam logic [7:0] O_ADD  = 8'b0001_1010;
  localparam logic [7:0] O_BUSY = 8'b0000_0010;
  localparam logic [7:0] O_DONE = 8'b0000_0110;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("reset_outs0", {8'd0, outs0}, {8'd0, O_IDLE});
    chk("reset_outs1", {8'd0, outs1}, {8'd0, O_IDLE});
    rst = 1'b1;
    step();

    // A=5, B=3
    opa = 15'd5; opb = 15'd3;
    start0 = 1'b1; step(); start0 = 1'b0;
    chk("m53_c1", {8'd0, outs0}, {8'd0, O_LDA});
    step(); chk("m53_c2", {8'd0, outs0}, {8'd0, O_LDB});
    for (int i = 3; i <= 5; i++) begin
      step(); chk($sformatf("m53_c%0d", i), {8'd0, outs0}, {8'd0, O_ADD});
    end
    step(); chk("m53_c6", {8'd0, outs0}, {8'd0, O_BUSY});
    step(); chk("m53_c7_done", {8'd0, outs0}, {8'd0, O_DONE});
    step(); chk("m53_c8_idle", {8'd0, outs0}, {8'd0, O_IDLE});
    chk("m53_p", rp, 16'd15);

    // A=9, B=0
    opa = 15'd9; opb = 15'd0;
    start0 = 1'b1; step(); start0 = 1'b0;
    chk("m90_c1", {8'd0, outs0}, {8'd0, O_LDA});
    step(); chk("m90_c2", {8'd0, outs0}, {8'd0, O_LDB});
    step(); chk("m90_c3", {8'd0, outs0}, {8'd0, O_BUSY});
    step(); chk("m90_c4_done", {8'd0, outs0}, {8'd0, O_DONE});
    step(); chk("m90_c5_idle", {8'd0, outs0}, {8'd0, O_IDLE});
    chk("m90_p", rp, 16'd0);

    // A=2, B=6 with start held through cycles 1-3, abort in cycle 4
    opa = 15'd2; opb = 15'd6;
    start0 = 1'b1; step();
    chk("ab_c1", {8'd0, outs0}, {8'd0, O_LDA});
    step(); chk("ab_c2", {8'd0, outs0}, {8'd0, O_LDB});
    step(); chk("ab_c3", {8'd0, outs0}, {8'd0, O_ADD});
    step(); start0 = 1'b0; abort0 = 1'b1; #1;
    chk("ab_c4_abort", {8'd0, outs0}, {8'd0, O_BUSY});
    step(); abort0 = 1'b0;
    chk("ab_c5_idle", {8'd0, outs0}, {8'd0, O_IDLE});
    for (int i = 6; i <= 9; i++) begin
      step(); chk($sformatf("ab_c%0d_nodone", i), {8'd0, outs0}, {8'd0, O_IDLE});
    end

    // start and abort together in IDLE
    start0 = 1'b1; abort0 = 1'b1; #1;
    chk("sa_same", {8'd0, outs0}, {8'd0, O_IDLE});
    step(); start0 = 1'b0; abort0 = 1'b0;
    chk("sa_next", {8'd0, outs0}, {8'd0, O_IDLE});
    step(); chk("sa_next2", {8'd0, outs0}, {8'd0, O_IDLE});

    // Reset mid-ADD
    opa = 15'd5; opb = 15'd3;
    start0 = 1'b1; step(); start0 = 1'b0;
    step(); step();
    chk("rs_c3_add", {8'd0, outs0}, {8'd0, O_ADD});
    rst = 1'b0; #1;
    chk("rs_async", {8'd0, outs0}, {8'd0, O_IDLE});
    step(); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); chk($sformatf("rs_after%0d", i), {8'd0, outs0}, {8'd0, O_IDLE});
    end

    // Watchdog: MAX_ITER=4, eqz stuck low
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("wd_c1", {8'd0, outs1}, {8'd0, O_LDA});
    step(); chk("wd_c2", {8'd0, outs1}, {8'd0, O_LDB});
    for (int i = 3; i <= 6; i++) begin
      step(); chk($sformatf("wd_c%0d", i), {8'd0, outs1}, {8'd0, O_ADD});
    end
    step(); chk("wd_c7_trip", {8'd0, outs1}, {8'd0, O_BUSY});
    step(); chk("wd_c8_done", {8'd0, outs1}, {8'd0, 8'b0000_0111});
    step(); chk("wd_c9_sticky", {8'd0, outs1}, {8'd0, 8'b0000_0001});
    abort1 = 1'b1; step(); abort1 = 1'b0;
    chk("wd_abort_hold", {8'd0, outs1}, {8'd0, 8'b0000_0001});
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("wd_restart_clr", {8'd0, outs1}, {8'd0, O_LDA});
    abort1 = 1'b1; step(); abort1 = 1'b0;
    chk("wd_restart_abort", {8'd0, outs1}, {8'd0, O_IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_control_path.md
# mult_control_path

Control path for the shift-free repeated-addition multiplier datapath (operand registers A and B on a shared 15-bit input bus, accumulator P, adder A+P, zero flag on B). It accepts a start request, sequences operand loads off the shared bus, and iterates P ← P + A while decrementing B until the datapath reports B == 0. It then reports completion with a one-cycle done pulse. A watchdog bounds the iteration count and flags a datapath fault if `eqz` never rises.

## Interface

Parameters:
- CNT_W, 16, width of the internal iteration counter.
- MAX_ITER, 32767, maximum ld_p pulses per operation before fault; must be < 2^CNT_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; clears all state immediately.
- start  input  1  request an operation; sampled only in IDLE.
- abort  input  1  synchronous cancel; valid in any state.
- eqz  input  1  datapath flag, 1 when B register == 0 (combinational from B).
- ld_a  output  1  load A from bus.
- ld_b  output  1  load B from bus.
- clr_p  output  1  clear P to 0.
- ld_p  output  1  load P with adder output (A+P).
- dec_b  output  1  decrement B.
- busy  output  1  1 whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky watchdog fault flag.

## Operation

- States: IDLE, LOAD_A, LOAD_B, ADD, DONE.
- IDLE: all strobes 0. If start=1 and abort=0, go to LOAD_A and clear err and the iteration counter.
- LOAD_A: ld_a=1. The producer must drive operand A on the bus this cycle. Next state is LOAD_B.
- LOAD_B: ld_b=1 and clr_p=1. The producer must drive operand B on the bus this cycle. Next state is ADD.
- ADD, while eqz=0:
  - ld_p=1 and dec_b=1; iteration counter increments.
  - If the counter already equals MAX_ITER, suppress both strobes, set err=1 and go to DONE.
- ADD, when eqz=1: ld_p=0 and dec_b=0; go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Strobe outputs (ld_a, ld_b, clr_p, ld_p, dec_b, done) are combinational from state and eqz.
  - At most one of ld_a / ld_b / ld_p is high in any cycle.
  - clr_p and ld_p are never high together.
- abort=1 has these effects:
  - Forces every strobe and done to 0 in that same cycle.
  - Next state is IDLE; the counter clears; err holds its value.
  - abort has priority over start and over every transition.
- start while busy=1 is ignored and not queued.
- err stays high after DONE until the next accepted start or reset.

## Timing

- Reset (rst=0): state IDLE, counter 0. Outputs ld_a, ld_b, clr_p, ld_p, dec_b, done, busy and err are all 0.
- Take start sampled high at edge 0 in IDLE. Then:
  - LOAD_A occupies cycle 1.
  - LOAD_B occupies cycle 2.
  - ADD occupies cycles 3 to 3+B.
  - done is high in cycle 4+B.
- Latency from start sample to done is B+4 cycles. Operand A has no effect on latency.
- busy is high from cycle 1 through cycle 4+B inclusive.
- The earliest next start is accepted in cycle 5+B, when state is back in IDLE.
- B=0 gives done in cycle 4 with zero ld_p pulses, so P remains 0.
- The ld_p count per operation equals B, provided B ≤ MAX_ITER.
- rst asserted mid-operation returns outputs to 0 asynchronously. No done is produced.

## Test plan

- Reset mid-ADD (rst low for 1 cycle) -> every output 0 immediately; busy=0 after release; no done.
- start, A=5, B=3 -> ld_a in cycle 1, ld_b+clr_p in cycle 2, ld_p/dec_b high in cycles 3-5, done in cycle 7, P=15, err=0.
- start, A=9, B=0 -> done in cycle 4, zero ld_p pulses, P=0.
- MAX_ITER=4, eqz tied 0, start -> 4 ld_p pulses, err=1 with done in cycle 8; err stays 1 until the next start.
- abort in cycle 4 of an A=2, B=6 run -> strobes 0 that cycle, IDLE next cycle, no done. A start during busy cycles 1-3 is ignored.
- start and abort high together in IDLE -> remain IDLE, busy=0, no strobes.
